// File: rtl/mips_decode_bundle.sv
// mips_decode_bundle: registered multi-lane MIPS decode stage between fetch and register read.
// Latency: an accepted bundle is presented one edge later; each split-off remainder takes one more output slot.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready is low while a remainder is pending or the output stalls.
// Ports: clk, rst (async, active-high), flush (sync kill);
//        fetch side  in_valid/in_ready, in_pc, in_inst (lane k at [32k+31:32k]), in_mask;
//        decode side out_valid/out_ready, out_pc, out_mask and per-lane control fields out_alu_sel .. out_ri.
module mips_decode_bundle #(
  parameter int LANES = 2,
  parameter int PC_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [32*LANES-1:0] in_inst,
  input  logic [LANES-1:0]    in_mask,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [LANES-1:0]    out_mask,
  output logic [4*LANES-1:0]  out_alu_sel,
  output logic [LANES-1:0]    out_we,
  output logic [5*LANES-1:0]  out_rd,
  output logic [2*LANES-1:0]  out_ins_type,
  output logic [LANES-1:0]    out_alu_src,
  output logic [LANES-1:0]    out_mem_to_reg,
  output logic [LANES-1:0]    out_imm_sign,
  output logic [LANES-1:0]    out_is_shift,
  output logic [3*LANES-1:0]  out_mem_bytes,
  output logic [4*LANES-1:0]  out_mem_wen,
  output logic [LANES-1:0]    out_sys,
  output logic [LANES-1:0]    out_ri
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_LUI = 4'd10;
  localparam logic [1:0] R_TYPE = 2'd0, I_TYPE = 2'd1, J_TYPE = 2'd2, B_TYPE = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J   = 6'b000010, OP_JAL  = 6'b000011,
                         OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_BLEZ = 6'b000110,
                         OP_BGTZ  = 6'b000111, OP_LB  = 6'b100000, OP_LH   = 6'b100001,
                         OP_LW    = 6'b100011, OP_LBU = 6'b100100, OP_LHU  = 6'b100101,
                         OP_SB    = 6'b101000, OP_SH  = 6'b101001, OP_SW   = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SYSCALL = 6'b001100,
                         F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010,
                         F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101,
                         F_XOR = 6'b100110, F_NOR = 6'b100111, F_SLT = 6'b101010,
                         F_SLTU = 6'b101011;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       we;
    logic [4:0] rd;
    logic [1:0] ins_type;
    logic       alu_src;
    logic       mem_to_reg;
    logic       imm_sign;
    logic       is_shift;
    logic [2:0] mem_bytes;
    logic [3:0] mem_wen;
    logic       sys;
    logic       ri;
  } dec_t;

  typedef enum logic {IDLE, SPLIT} state_t;

  function automatic dec_t decode_lane(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] funct);
    dec_t d;
    d = '0;
    if (op[5:3] == 3'b001) begin
      // ALU-immediate group; logical ops and LUI zero-extend (op[2] set).
      d.ins_type = I_TYPE;
      d.alu_src  = 1'b1;
      d.we       = 1'b1;
      d.rd       = rt;
      d.imm_sign = !op[2];
      case (op[2:0])
        3'd0, 3'd1: d.alu_sel = ALU_ADD;
        3'd2:       d.alu_sel = ALU_SLT;
        3'd3:       d.alu_sel = ALU_SLTU;
        3'd4:       d.alu_sel = ALU_AND;
        3'd5:       d.alu_sel = ALU_OR;
        3'd6:       d.alu_sel = ALU_XOR;
        default:    d.alu_sel = ALU_LUI;
      endcase
    end else begin
      case (op)
        OP_RTYPE: begin
          d.ins_type = R_TYPE;
          d.we       = 1'b1;
          d.rd       = rd;
          case (funct)
            F_ADD, F_ADDU: d.alu_sel = ALU_ADD;
            F_SUB, F_SUBU: d.alu_sel = ALU_SUB;
            F_AND:         d.alu_sel = ALU_AND;
            F_OR:          d.alu_sel = ALU_OR;
            F_XOR:         d.alu_sel = ALU_XOR;
            F_NOR:         d.alu_sel = ALU_NOR;
            F_SLT:         d.alu_sel = ALU_SLT;
            F_SLTU:        d.alu_sel = ALU_SLTU;
            F_SLL: begin d.alu_sel = ALU_SLL; d.is_shift = 1'b1; end
            F_SRL: begin d.alu_sel = ALU_SRL; d.is_shift = 1'b1; end
            F_SYSCALL: begin d.we = 1'b0; d.sys = 1'b1; end
            default:   begin d.we = 1'b0; d.ri = 1'b1; end
          endcase
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          d.ins_type   = I_TYPE;
          d.alu_sel    = ALU_ADD;
          d.alu_src    = 1'b1;
          d.mem_to_reg = 1'b1;
          d.we         = 1'b1;
          d.rd         = rt;
          d.imm_sign   = !op[2];
          d.mem_bytes  = (op[1:0] == 2'b00) ? 3'd1 : (op[1:0] == 2'b01) ? 3'd2 : 3'd4;
        end
        OP_SB, OP_SH, OP_SW: begin
          d.ins_type  = I_TYPE;
          d.alu_sel   = ALU_ADD;
          d.alu_src   = 1'b1;
          d.imm_sign  = 1'b1;
          d.mem_bytes = (op[1:0] == 2'b00) ? 3'd1 : (op[1:0] == 2'b01) ? 3'd2 : 3'd4;
          d.mem_wen   = (op[1:0] == 2'b00) ? 4'b0001 : (op[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
        end
        OP_J:   d.ins_type = J_TYPE;
        OP_JAL: begin d.ins_type = J_TYPE; d.we = 1'b1; d.rd = 5'd31; end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
          d.ins_type = B_TYPE;
          d.alu_sel  = ALU_SUB;
          d.imm_sign = 1'b1;
        end
        default: d.ri = 1'b1;
      endcase
    end
    if (!d.we) d.rd = '0;
    return d;
  endfunction

  // Registered state
  state_t                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [PC_W-1:0]         out_pc_q, out_pc_d;
  logic [LANES-1:0]        out_mask_q, out_mask_d;
  dec_t [LANES-1:0]        out_dec_q, out_dec_d;
  logic [PC_W-1:0]         res_pc_q, res_pc_d;
  logic [32*LANES-1:0]     res_inst_q, res_inst_d;
  logic [LANES-1:0]        res_mask_q, res_mask_d;

  // Split engine signals
  logic [PC_W-1:0]         src_pc;
  logic [32*LANES-1:0]     src_inst;
  logic [LANES-1:0]        src_mask;
  dec_t [LANES-1:0]        lane_dec;
  dec_t [LANES-1:0]        issued_dec;
  logic [LANES-1:0]        issue;
  logic [2:0]              n_issue;
  logic                    stop, dep, drop;
  logic [PC_W-1:0]         res_nxt_pc;
  logic [32*LANES-1:0]     res_nxt_inst;
  logic [LANES-1:0]        res_nxt_mask;
  logic                    slot_free, load_out;
  logic                    unused_shamt;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free && !flush;

  // The residual register holds the remainder compacted to lane 0, so the
  // same engine serves both fresh bundles and remainders.
  assign src_pc   = (state_q == SPLIT) ? res_pc_q   : in_pc;
  assign src_inst = (state_q == SPLIT) ? res_inst_q : in_inst;
  assign src_mask = (state_q == SPLIT) ? res_mask_q : in_mask;

  always_comb begin
    unused_shamt = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_dec[k] = decode_lane(src_inst[32*k+26 +: 6], src_inst[32*k+16 +: 5],
                                src_inst[32*k+11 +: 5], src_inst[32*k +: 6]);
      // shamt is consumed by execute, not by decode.
      unused_shamt = unused_shamt ^ (^src_inst[32*k+6 +: 5]);
    end

    issue   = '0;
    n_issue = '0;
    stop    = 1'b0;
    drop    = 1'b0;
    dep     = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      dep = 1'b0;
      for (int i = 0; i < j; i++) begin
        if (lane_dec[i].we && (lane_dec[i].rd != 5'd0) &&
            ((src_inst[32*j+21 +: 5] == lane_dec[i].rd) ||
             (src_inst[32*j+16 +: 5] == lane_dec[i].rd)))
          dep = 1'b1;
      end
      if (src_mask[j] && !stop) begin
        if (dep) begin
          stop = 1'b1;
        end else begin
          issue[j] = 1'b1;
          n_issue  = n_issue + 3'd1;
          // An excepting lane ends the bundle; younger lanes are discarded.
          if (lane_dec[j].sys || lane_dec[j].ri) begin
            stop = 1'b1;
            drop = 1'b1;
          end
        end
      end
    end

    for (int k = 0; k < LANES; k++)
      issued_dec[k] = issue[k] ? lane_dec[k] : '0;

    res_nxt_mask = drop ? '0 : ((src_mask & ~issue) >> n_issue);
    res_nxt_pc   = src_pc + PC_W'({n_issue, 2'b00});
    res_nxt_inst = '0;
    for (int k = 0; k < LANES; k++)
      for (int s = 0; s < LANES - k; s++)
        if (s == int'(n_issue)) res_nxt_inst[32*k +: 32] = src_inst[32*(k+s) +: 32];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_mask_d  = out_mask_q;
    out_dec_d   = out_dec_q;
    res_pc_d    = res_pc_q;
    res_inst_d  = res_inst_q;
    res_mask_d  = res_mask_q;
    load_out    = 1'b0;

    if (flush) begin
      out_valid_d = 1'b0;
      res_mask_d  = '0;
      state_d     = IDLE;
    end else if (state_q == SPLIT) begin
      load_out = slot_free;
    end else if (in_valid && in_ready) begin
      // An empty bundle is swallowed and leaves the output slot empty.
      if (in_mask != '0) load_out = 1'b1;
      else               out_valid_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load_out) begin
      out_valid_d = 1'b1;
      out_pc_d    = src_pc;
      out_mask_d  = issue;
      out_dec_d   = issued_dec;
      res_pc_d    = res_nxt_pc;
      res_inst_d  = res_nxt_inst;
      res_mask_d  = res_nxt_mask;
      state_d     = (res_nxt_mask != '0) ? SPLIT : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_mask_q  <= '0;
      out_dec_q   <= '0;
      res_pc_q    <= '0;
      res_inst_q  <= '0;
      res_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_mask_q  <= out_mask_d;
      out_dec_q   <= out_dec_d;
      res_pc_q    <= res_pc_d;
      res_inst_q  <= res_inst_d;
      res_mask_q  <= res_mask_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_mask  = out_mask_q;

  for (genvar k = 0; k < LANES; k++) begin : g_out
    assign out_alu_sel[4*k +: 4]   = out_dec_q[k].alu_sel;
    assign out_we[k]               = out_dec_q[k].we;
    assign out_rd[5*k +: 5]        = out_dec_q[k].rd;
    assign out_ins_type[2*k +: 2]  = out_dec_q[k].ins_type;
    assign out_alu_src[k]          = out_dec_q[k].alu_src;
    assign out_mem_to_reg[k]       = out_dec_q[k].mem_to_reg;
    assign out_imm_sign[k]         = out_dec_q[k].imm_sign;
    assign out_is_shift[k]         = out_dec_q[k].is_shift;
    assign out_mem_bytes[3*k +: 3] = out_dec_q[k].mem_bytes;
    assign out_mem_wen[4*k +: 4]   = out_dec_q[k].mem_wen;
    assign out_sys[k]              = out_dec_q[k].sys;
    assign out_ri[k]               = out_dec_q[k].ri;
  end

endmodule

// File: tb/tb_mips_decode_bundle.sv
// tb_mips_decode_bundle: directed bench for the two-lane decode stage.
// Expected bundles are queued when stimulus is driven and compared when the consumer takes them.
module tb_mips_decode_bundle;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [1:0]  out_mask;
  logic [7:0]  out_alu_sel;
  logic [1:0]  out_we;
  logic [9:0]  out_rd;
  logic [3:0]  out_ins_type;
  logic [1:0]  out_alu_src;
  logic [1:0]  out_mem_to_reg;
  logic [1:0]  out_imm_sign;
  logic [1:0]  out_is_shift;
  logic [5:0]  out_mem_bytes;
  logic [7:0]  out_mem_wen;
  logic [1:0]  out_sys;
  logic [1:0]  out_ri;

  mips_decode_bundle #(.LANES(2), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_mask(out_mask),
    .out_alu_sel(out_alu_sel), .out_we(out_we), .out_rd(out_rd), .out_ins_type(out_ins_type),
    .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg), .out_imm_sign(out_imm_sign),
    .out_is_shift(out_is_shift), .out_mem_bytes(out_mem_bytes), .out_mem_wen(out_mem_wen),
    .out_sys(out_sys), .out_ri(out_ri)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [9:0]  rd;
    logic [1:0]  we;
    logic [1:0]  sys;
    logic [1:0]  ri;
    logic [7:0]  alu;
    logic [5:0]  mb;
    logic [7:0]  mw;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Instruction words
  localparam logic [31:0] I_ADD  = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] I_ORI  = 32'h34c50001;  // ori $5,$6,1
  localparam logic [31:0] I_SUB  = 32'h00612022;  // sub $4,$3,$1
  localparam logic [31:0] I_SYS  = 32'h0000000C;  // syscall
  localparam logic [31:0] I_BAD  = 32'hFC000000;  // opcode 0x3F
  localparam logic [31:0] I_LW   = 32'h8C470004;  // lw $7,4($2)
  localparam logic [31:0] I_SW   = 32'hAD280000;  // sw $8,0($9)
  localparam logic [31:0] I_ADD0 = 32'h00220020;  // add $0,$1,$2
  localparam logic [31:0] I_SUB0 = 32'h00012022;  // sub $4,$0,$1
  localparam logic [31:0] I_SLL  = 32'h00011100;  // sll $2,$1,4
  localparam logic [31:0] I_LBU  = 32'h91090000;  // lbu $9,0($8)

  function automatic exp_t mk(input logic [31:0] pc, input logic [1:0] mask, input logic [9:0] rd,
                              input logic [1:0] we, input logic [1:0] sys, input logic [1:0] ri,
                              input logic [7:0] alu, input logic [5:0] mb, input logic [7:0] mw);
    exp_t e;
    e.pc = pc; e.mask = mask; e.rd = rd; e.we = we; e.sys = sys; e.ri = ri;
    e.alu = alu; e.mb = mb; e.mw = mw;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called at the falling edge: a bundle with out_valid && out_ready is consumed at the next rise.
  task automatic sample();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("out_pc",        64'(out_pc),        64'(e.pc));
        check("out_mask",      64'(out_mask),      64'(e.mask));
        check("out_rd",        64'(out_rd),        64'(e.rd));
        check("out_we",        64'(out_we),        64'(e.we));
        check("out_sys",       64'(out_sys),       64'(e.sys));
        check("out_ri",        64'(out_ri),        64'(e.ri));
        check("out_alu_sel",   64'(out_alu_sel),   64'(e.alu));
        check("out_mem_bytes", 64'(out_mem_bytes), 64'(e.mb));
        check("out_mem_wen",   64'(out_mem_wen),   64'(e.mw));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rdy(input logic expv);
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(expv));
    sample();
    @(posedge clk);
    #1;
  endtask

  // Presents one bundle for exactly one edge; it must be accepted.
  task automatic send(input logic [31:0] pc, input logic [63:0] inst, input logic [1:0] mask);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    in_mask  = mask;
    @(negedge clk);
    check("in_ready_accept", 64'(in_ready), 64'(1));
    sample();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    in_mask   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid),   64'(0));
    check("rst_out_pc",    64'(out_pc),      64'(0));
    check("rst_out_mask",  64'(out_mask),    64'(0));
    check("rst_out_rd",    64'(out_rd),      64'(0));
    check("rst_out_we",    64'(out_we),      64'(0));
    check("rst_out_alu",   64'(out_alu_sel), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Independent pair: both lanes issue together, one edge after acceptance.
    sb.push_back(mk(32'h400, 2'b11, {5'd5, 5'd3}, 2'b11, 2'b00, 2'b00, 8'h30, 6'h00, 8'h00));
    send(32'h400, {I_ORI, I_ADD}, 2'b11);
    check("lat1_valid", 64'(out_valid), 64'(1));
    tick();

    // RAW dependence splits the bundle over two output slots.
    sb.push_back(mk(32'h400, 2'b01, {5'd0, 5'd3}, 2'b01, 2'b00, 2'b00, 8'h00, 6'h00, 8'h00));
    sb.push_back(mk(32'h404, 2'b01, {5'd0, 5'd4}, 2'b01, 2'b00, 2'b00, 8'h01, 6'h00, 8'h00));
    send(32'h400, {I_SUB, I_ADD}, 2'b11);
    tick_rdy(1'b0);
    tick();

    // Syscall in lane 0 kills lane 1.
    sb.push_back(mk(32'h500, 2'b01, 10'd0, 2'b00, 2'b01, 2'b00, 8'h00, 6'h00, 8'h00));
    send(32'h500, {I_ADD, I_SYS}, 2'b11);
    tick_rdy(1'b1);
    check("sys_no_residual", 64'(out_valid), 64'(0));

    // Reserved opcode in lane 0.
    sb.push_back(mk(32'h600, 2'b01, 10'd0, 2'b00, 2'b00, 2'b01, 8'h00, 6'h00, 8'h00));
    send(32'h600, {I_ADD, I_BAD}, 2'b11);
    tick();
    check("ri_no_residual", 64'(out_valid), 64'(0));

    // Load + store pair.
    sb.push_back(mk(32'h900, 2'b11, {5'd0, 5'd7}, 2'b01, 2'b00, 2'b00, 8'h00, {3'd4, 3'd4}, 8'hF0));
    send(32'h900, {I_SW, I_LW}, 2'b11);
    check("ls_imm_sign",   64'(out_imm_sign),   64'(2'b11));
    check("ls_mem_to_reg", 64'(out_mem_to_reg), 64'(2'b01));
    tick();

    // Writing $0 never creates a dependence.
    sb.push_back(mk(32'hA00, 2'b11, {5'd4, 5'd0}, 2'b11, 2'b00, 2'b00, 8'h10, 6'h00, 8'h00));
    send(32'hA00, {I_SUB0, I_ADD0}, 2'b11);
    tick();

    // Shift + unsigned byte load.
    sb.push_back(mk(32'hB80, 2'b11, {5'd9, 5'd2}, 2'b11, 2'b00, 2'b00, 8'h08, {3'd1, 3'd0}, 8'h00));
    send(32'hB80, {I_LBU, I_SLL}, 2'b11);
    check("sh_is_shift",   64'(out_is_shift),   64'(2'b01));
    check("sh_imm_sign",   64'(out_imm_sign),   64'(2'b00));
    check("sh_mem_to_reg", 64'(out_mem_to_reg), 64'(2'b10));
    check("sh_alu_src",    64'(out_alu_src),    64'(2'b10));
    check("sh_ins_type",   64'(out_ins_type),   64'(4'b0100));
    tick();

    // Residual PC wraps modulo 2^32.
    sb.push_back(mk(32'hFFFFFFFC, 2'b01, {5'd0, 5'd3}, 2'b01, 2'b00, 2'b00, 8'h00, 6'h00, 8'h00));
    sb.push_back(mk(32'h00000000, 2'b01, {5'd0, 5'd4}, 2'b01, 2'b00, 2'b00, 8'h01, 6'h00, 8'h00));
    send(32'hFFFFFFFC, {I_SUB, I_ADD}, 2'b11);
    tick_rdy(1'b0);
    tick();

    // Empty mask: accepted, nothing presented.
    send(32'h800, {I_ORI, I_ADD}, 2'b00);
    check("mask0_no_out", 64'(out_valid), 64'(0));
    check("mask0_ready",  64'(in_ready),  64'(1));

    // Backpressure: five stalled cycles, outputs hold, then consumed once.
    out_ready = 1'b0;
    sb.push_back(mk(32'h700, 2'b11, {5'd5, 5'd3}, 2'b11, 2'b00, 2'b00, 8'h30, 6'h00, 8'h00));
    send(32'h700, {I_ORI, I_ADD}, 2'b11);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid",    64'(out_valid),    64'(1));
      check("bp_in_ready", 64'(in_ready),     64'(0));
      check("bp_pc",       64'(out_pc),       64'(32'h700));
      check("bp_mask",     64'(out_mask),     64'(2'b11));
      check("bp_rd",       64'(out_rd),       64'({5'd5, 5'd3}));
      check("bp_ins_type", 64'(out_ins_type), 64'(4'b0100));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    tick();
    check("bp_once", 64'(out_valid), 64'(0));

    // Flush while a residual is held, with a competing input bundle.
    out_ready = 1'b0;
    send(32'hB00, {I_SUB, I_ADD}, 2'b11);
    check("pre_flush_valid", 64'(out_valid), 64'(1));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'hC00;
    in_inst  = {I_ORI, I_ADD};
    in_mask  = 2'b11;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    sample();
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("flush_idle_ready", 64'(in_ready), 64'(1));
    sample();
    @(posedge clk);
    #1;
    check("flush_no_capture", 64'(out_valid), 64'(0));

    // Reset while a residual is held.
    out_ready = 1'b0;
    send(32'hD00, {I_SUB, I_ADD}, 2'b11);
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'(0));
    check("rst_async_mask",  64'(out_mask),  64'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready),  64'(1));
    check("post_rst_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check("post_rst_no_residual", 64'(out_valid), 64'(0));

    sb.push_back(mk(32'hE00, 2'b11, {5'd5, 5'd3}, 2'b11, 2'b00, 2'b00, 8'h30, 6'h00, 8'h00));
    send(32'hE00, {I_ORI, I_ADD}, 2'b11);
    tick();
    tick();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
